// File: rtl/math_pkg.sv
// Shared types and elaboration helpers for the digit-serial math blocks.
package math_pkg;

    // Sequencer states of the serial add/subtract unit.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digits an operand splits into.
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Width of the RUN-cycle counter; it must be able to hold N itself.
    function automatic int count_width(input int width, input int digit);
        return $clog2(width / digit) + 1;
    endfunction

    // True when the operand width is a whole number of digits.
    function automatic bit digit_fit_ok(input int width, input int digit);
        return (digit > 0) && (width % digit == 0);
    endfunction

endpackage

// File: rtl/digit_addsub.sv
// One DIGIT-bit add/subtract slice: the digit-wide, two-mode form of the
// single-bit full-minuser cell. In subtract mode cin/cout are borrows.
module digit_addsub #(
    parameter int DIGIT = 4
) (
    input  logic             sub,
    input  logic             cin,
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic [DIGIT-1:0] d,
    output logic             cout
);

    logic [DIGIT:0] t;

    // One extra bit catches the carry (add) or the sign of a negative difference (borrow).
    always_comb begin
        t = '0;
        if (sub) begin
            t = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, cin};
        end else begin
            t = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
        end
    end

    assign d    = t[DIGIT-1:0];
    assign cout = t[DIGIT];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial add/subtract unit: WIDTH-bit operands processed DIGIT bits
// per cycle through one reusable digit slice, with optional early completion.
//
// Handshake (four-phase req/fin): a request is accepted at an edge in IDLE
// with req=1; x, y and sub are captured there and may change afterwards.
// fin rises with the result and stays high while req stays high; the first
// edge with req=0 in DONE drops fin and busy and returns to IDLE. req
// dropped while the operation runs is ignored, giving a one-cycle fin pulse.
module serial_addsub_unit
    import math_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIGIT     = 4,
    parameter int EARLY_FIN = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req,
    input  logic                           sub,
    input  logic [WIDTH-1:0]               x,
    input  logic [WIDTH-1:0]               y,
    output logic                           busy,
    output logic                           fin,
    output logic [WIDTH-1:0]               s,
    output logic                           cout,
    output logic [$clog2(WIDTH/DIGIT):0]   cycles,
    output logic [1:0]                     dbg_state
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = count_width(WIDTH, DIGIT);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (!digit_fit_ok(WIDTH, DIGIT)) begin : g_bad_digit
        $error("serial_addsub_unit: WIDTH must be a multiple of DIGIT");
    end

    state_t         state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic           sub_r;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;

    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT-1:0] d_dig;
    logic             c_dig;
    logic             y_rest_zero;
    logic             early_ok;
    logic             last_dig;
    logic [WIDTH-1:0] upper_mask;
    logic [WIDTH-1:0] s_early;

    // Select the current digit and decide whether the rest of the result is just x.
    always_comb begin
        x_dig       = xr[int'(idx)*DIGIT +: DIGIT];
        y_dig       = yr[int'(idx)*DIGIT +: DIGIT];
        y_rest_zero = ((yr >> (int'(idx) * DIGIT)) == '0);
        early_ok    = (EARLY_FIN != 0) && !carry && y_rest_zero;
        last_dig    = (int'(idx) == N - 1);
        upper_mask  = {WIDTH{1'b1}} << (int'(idx) * DIGIT);
        s_early     = (s & ~upper_mask) | (xr & upper_mask);
    end

    digit_addsub #(.DIGIT(DIGIT)) u_digit (
        .sub  (sub_r),
        .cin  (carry),
        .a    (x_dig),
        .b    (y_dig),
        .d    (d_dig),
        .cout (c_dig)
    );

    assign dbg_state = state;

    // Sequencer: accept, step one digit per RUN cycle, hold the result in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            sub_r  <= 1'b0;
            xr     <= '0;
            yr     <= '0;
            busy   <= 1'b0;
            fin    <= 1'b0;
            s      <= '0;
            cout   <= 1'b0;
            cycles <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        xr     <= x;
                        yr     <= y;
                        sub_r  <= sub;
                        carry  <= 1'b0;
                        idx    <= '0;
                        cycles <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    cycles <= cycles + 1'b1;
                    if (early_ok) begin
                        s     <= s_early;
                        cout  <= 1'b0;
                        fin   <= 1'b1;
                        state <= DONE;
                    end else begin
                        s[int'(idx)*DIGIT +: DIGIT] <= d_dig;
                        carry <= c_dig;
                        idx   <= idx + 1'b1;
                        if (last_dig) begin
                            cout  <= c_dig;
                            fin   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!req) begin
                        fin   <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_cw;
    assign unused_cw = (CW == 0);

endmodule
